// File: rtl/fifo_drain_arbiter_if.sv
// rtl/fifo_drain_arbiter_if.sv - channel FIFO read ports and tagged output stream of the drain arbiter
interface fifo_drain_arbiter_if #(
  parameter int CH_BITS   = 2,
  parameter int DATA_SIZE = 8
);
  localparam int NUM_CH = 1 << CH_BITS;

  logic [NUM_CH-1:0]           ch_enable;
  logic [NUM_CH-1:0]           ch_empty;
  logic [NUM_CH*DATA_SIZE-1:0] ch_data;
  logic [NUM_CH-1:0]           ch_inc;
  logic [DATA_SIZE-1:0]        out_data;
  logic [CH_BITS-1:0]          out_ch;
  logic                        out_sop;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  modport slave (
    input  ch_enable, ch_empty, ch_data, out_ready,
    output ch_inc, out_data, out_ch, out_sop, out_valid, busy
  );

  modport master (
    output ch_enable, ch_empty, ch_data, out_ready,
    input  ch_inc, out_data, out_ch, out_sop, out_valid, busy
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin burst drain of per-channel show-ahead FIFOs into one stream
module fifo_drain_arbiter #(
  parameter int CH_BITS   = 2,
  parameter int DATA_SIZE = 8,
  parameter int BURST     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_drain_arbiter_if.slave  bus
);
  localparam int NUM_CH = 1 << CH_BITS;
  localparam int CNT_W  = $clog2(BURST + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_XFER} state_e;

  state_e               state_q, state_d;
  logic                 startup_q, startup_d;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_BITS-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic [CH_BITS-1:0]   out_ch_q, out_ch_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_valid_q, out_valid_d;

  logic                 hit;
  logic [CH_BITS-1:0]   hit_ch;
  logic                 pop;
  logic [DATA_SIZE-1:0] head;

  assign head = bus.ch_data[int'(gnt_q)*DATA_SIZE +: DATA_SIZE];

  // Walk offsets from the far end so the closest eligible channel to rr_ptr wins.
  always_comb begin
    hit    = 1'b0;
    hit_ch = rr_ptr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.ch_enable[rr_ptr_q + CH_BITS'(k)] && !bus.ch_empty[rr_ptr_q + CH_BITS'(k)]) begin
        hit    = 1'b1;
        hit_ch = rr_ptr_q + CH_BITS'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    startup_d   = startup_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_sop_d   = out_sop_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_STARTUP: begin
        startup_d = !startup_q;
        if (startup_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (hit) begin
          gnt_d   = hit_ch;
          count_d = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!bus.ch_enable[gnt_q] || bus.ch_empty[gnt_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_q + CH_BITS'(1);
        end else if (!out_valid_q || bus.out_ready) begin
          pop         = 1'b1;
          out_data_d  = head;
          out_ch_d    = gnt_q;
          out_sop_d   = (count_q == '0);
          out_valid_d = 1'b1;
          count_d     = count_q + CNT_W'(1);
          if (count_q == CNT_W'(BURST - 1)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = gnt_q + CH_BITS'(1);
          end
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // Pop strobe is gated by rst_n so a reset cycle never consumes a FIFO word.
  always_comb begin
    bus.ch_inc = '0;
    if (pop && rst_n) begin
      bus.ch_inc = NUM_CH'(1) << gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STARTUP;
      startup_q   <= 1'b0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sop_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      startup_q   <= startup_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_sop_q   <= out_sop_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_XFER);
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - self-checking bench for fifo_drain_arbiter
module tb_fifo_drain_arbiter;
  localparam int CH_BITS   = 2;
  localparam int DATA_SIZE = 8;
  localparam int BURST     = 4;
  localparam int NUM_CH    = 1 << CH_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.CH_BITS(CH_BITS), .DATA_SIZE(DATA_SIZE)) bus ();

  fifo_drain_arbiter #(.CH_BITS(CH_BITS), .DATA_SIZE(DATA_SIZE), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [DATA_SIZE-1:0] fifo_q [NUM_CH][$];
  logic [DATA_SIZE-1:0] exp_q  [NUM_CH][$];
  int                   acc_ch [$];
  logic                 acc_sop[$];
  int                   pop_log[$];
  int                   pop_cnt[NUM_CH];
  int                   cur_len, cur_ch, stall_cycles;
  logic                 prev_stall;
  logic [DATA_SIZE-1:0] prev_data;
  logic [CH_BITS-1:0]   prev_ch;
  logic [NUM_CH-1:0]    pend_pop;
  logic                 s_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_empty[i] = (fifo_q[i].size() == 0);
      bus.ch_data[i*DATA_SIZE +: DATA_SIZE] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input int n);
    logic [DATA_SIZE-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = DATA_SIZE'($urandom);
      fifo_q[ch].push_back(w);
      exp_q[ch].push_back(w);
    end
    refresh_inputs();
  endtask

  task automatic clear_logs();
    acc_ch.delete();
    acc_sop.delete();
    pop_log.delete();
    for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
    cur_len = 0;
    stall_cycles = 0;
    prev_stall = 1'b0;
  endtask

  // One clock: observe at negedge, then apply the FIFO pops just after posedge.
  task automatic step();
    int ch;
    @(negedge clk);
    pend_pop = bus.ch_inc;
    s_valid  = bus.out_valid;
    check("inc_onehot", 32'($onehot0(bus.ch_inc)), 1);
    check("inc_nonempty", 32'(bus.ch_inc & bus.ch_empty), 0);
    if (!rst_n) begin
      check("inc_in_reset", 32'(bus.ch_inc), 0);
      if (bus.out_valid) begin
        ch = int'(bus.out_ch);
        if (exp_q[ch].size() != 0) begin
          check("dropped_word", 32'(bus.out_data), 32'(exp_q[ch][0]));
          void'(exp_q[ch].pop_front());
        end else begin
          check("dropped_word_known", 0, 1);
        end
      end
      prev_stall = 1'b0;
      cur_len = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_ch", 32'(bus.out_ch), 32'(prev_ch));
      end
      check("no_pop_stalled", 32'(bus.out_valid && !bus.out_ready && (bus.ch_inc != 0)), 0);
      if (bus.out_valid && bus.out_ready) begin
        ch = int'(bus.out_ch);
        if (exp_q[ch].size() == 0) begin
          check("spurious_word", 0, 1);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_q[ch].pop_front()));
        end
        if (bus.out_sop) begin
          cur_len = 1;
          cur_ch  = ch;
        end else begin
          check("burst_cont", 32'(cur_len >= 1 && cur_len < BURST && ch == cur_ch), 1);
          cur_len++;
        end
        acc_ch.push_back(ch);
        acc_sop.push_back(bus.out_sop);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ch    = bus.out_ch;
      if (prev_stall) stall_cycles++;
    end
    pop_log.push_back(bus.ch_inc == 0 ? -1 : $clog2(bus.ch_inc));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_pop[i] && fifo_q[i].size() != 0) begin
        void'(fifo_q[i].pop_front());
        pop_cnt[i]++;
      end
    end
    refresh_inputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < n; c++) step();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_ch", 32'(bus.out_ch), 0);
    check("rst_out_sop", 32'(bus.out_sop), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    clear_logs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    bit done = 1'b0;
    bus.ch_enable = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = all_empty() && !s_valid;
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    int f, exp_p, n1, others, k1;
    bus.ch_enable = '0;
    bus.out_ready = 1'b0;
    bus.ch_empty  = '1;
    bus.ch_data   = '0;
    clear_logs();

    // T1: startup latency with every channel non-empty
    for (int i = 0; i < NUM_CH; i++) push(i, 1);
    bus.ch_enable = '1;
    do_reset(3);
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t1_no_pop_early", 32'(pend_pop), 0);
      check("t1_no_valid_early", 32'(s_valid), 0);
    end
    step();
    check("t1_first_pop_ch0", 32'(pend_pop), 32'h1);
    drain("t1_drain", 60);

    // T2: single channel, bursts 4,4,2 with one bubble between
    do_reset(2);
    push(2, 10);
    drain("t2_drain", 100);
    f = -1;
    foreach (pop_log[i]) if (f < 0 && pop_log[i] >= 0) f = i;
    for (int o = 0; o < 12; o++) begin
      exp_p = (o == 4 || o == 9) ? -1 : 2;
      check("t2_pop_pattern", (f >= 0 && f + o < pop_log.size()) ? 32'(pop_log[f+o]) : 32'hdead, 32'(exp_p));
    end
    check("t2_pop_total", 32'(pop_cnt[2]), 10);
    check("t2_words", 32'(acc_ch.size()), 10);
    for (int i = 0; i < acc_ch.size(); i++) begin
      check("t2_ch", 32'(acc_ch[i]), 2);
      check("t2_sop", 32'(acc_sop[i]), 32'(i == 0 || i == 4 || i == 8));
    end

    // T3: all channels loaded, round-robin order of full bursts
    do_reset(2);
    for (int i = 0; i < NUM_CH; i++) push(i, 8);
    drain("t3_drain", 200);
    check("t3_words", 32'(acc_ch.size()), 32);
    for (int i = 0; i < acc_ch.size(); i++) begin
      check("t3_ch", 32'(acc_ch[i]), 32'((i / 4) % 4));
      check("t3_sop", 32'(acc_sop[i]), 32'(i % 4 == 0));
    end

    // T4: consumer stall after word 2
    do_reset(2);
    push(0, 8);
    bus.ch_enable = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && acc_ch.size() < 2; c++) step();
    check("t4_reached_word2", 32'(acc_ch.size()), 2);
    bus.out_ready = 1'b0;
    stall_cycles = 0;
    for (int c = 0; c < 5; c++) step();
    check("t4_stall_cycles", 32'(stall_cycles), 5);
    drain("t4_drain", 80);
    check("t4_words", 32'(acc_ch.size()), 8);

    // T5: disable ch1 mid-burst, others keep being served
    do_reset(2);
    push(0, 6);
    push(1, 8);
    push(3, 6);
    bus.ch_enable = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && pop_cnt[1] < 2; c++) step();
    check("t5_ch1_two_pops", 32'(pop_cnt[1]), 2);
    bus.ch_enable[1] = 1'b0;
    others = pop_cnt[0] + pop_cnt[3];
    for (int c = 0; c < 15; c++) step();
    check("t5_ch1_frozen", 32'(pop_cnt[1]), 2);
    check("t5_others_served", 32'(pop_cnt[0] + pop_cnt[3] > others), 1);
    n1 = 0;
    foreach (acc_ch[i]) if (acc_ch[i] == 1) n1++;
    check("t5_ch1_words_before", 32'(n1), 2);
    drain("t5_drain", 120);
    n1 = 0;
    k1 = -1;
    foreach (acc_ch[i]) begin
      if (acc_ch[i] == 1) begin
        if (n1 == 2) k1 = i;
        n1++;
      end
    end
    check("t5_ch1_total", 32'(n1), 8);
    check("t5_resume_sop", (k1 >= 0) ? 32'(acc_sop[k1]) : 32'hdead, 1);

    // T6: reset while a ch3 word is held in the output register
    do_reset(2);
    push(3, 8);
    bus.ch_enable = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && pop_cnt[3] < 2; c++) step();
    check("t6_ch3_two_pops", 32'(pop_cnt[3]), 2);
    bus.out_ready = 1'b0;
    push(0, 4);
    do_reset(2);
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t6_no_pop_early", 32'(pend_pop), 0);
    end
    step();
    check("t6_restart_ch0", 32'(pend_pop), 32'h1);
    drain("t6_drain", 120);

    // T7: randomized enables, back-pressure and arrivals
    do_reset(2);
    bus.ch_enable = '1;
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) bus.ch_enable[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) push($urandom_range(0, NUM_CH-1), $urandom_range(1, 3));
      step();
    end
    drain("t7_drain", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
